// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor: FSM states, default
// parameter values and the saturating-counter update rule.
package bp_pkg;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  localparam int unsigned BP_HIST_W   = 7;
  localparam int unsigned BP_IDX_W    = 7;
  localparam int unsigned BP_CTR_W    = 2;
  localparam int unsigned BP_CTR_INIT = 1;
  localparam int unsigned BP_PC_W     = 32;
  localparam int unsigned BP_PC_LSB   = 0;

  // Counter carried in 32 bits so one function serves every CTR_W up to 32;
  // callers cast the result back to their own width.
  function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr,
                                               input logic        taken,
                                               input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    if (taken) begin
      return (ctr >= max_v) ? max_v : ctr + 32'd1;
    end else begin
      return (ctr == '0) ? '0 : ctr - 32'd1;
    end
  endfunction

endpackage

// File: rtl/sat_ctr_table.sv
// Pattern history table of saturating counters: one combinational read port
// for fetch, one write port shared by the init sweep and commit training.
module sat_ctr_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = BP_IDX_W,
  parameter int unsigned CTR_W    = BP_CTR_W,
  parameter int unsigned CTR_INIT = BP_CTR_INIT
) (
  input  logic             clk_i,
  input  logic             sweep_i,
  input  logic [IDX_W-1:0] sweep_idx_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CTR_W-1:0] rd_ctr_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [CTR_W-1:0] pht_q [DEPTH];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_data;

  // The sweep owns the write port outright; training is never merged with it.
  always_comb begin
    wr_en   = sweep_i | upd_en_i;
    wr_idx  = upd_idx_i;
    wr_data = CTR_W'(sat_ctr_next(32'(pht_q[upd_idx_i]), upd_taken_i, CTR_W));
    if (sweep_i) begin
      wr_idx  = sweep_idx_i;
      wr_data = CTR_W'(CTR_INIT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      pht_q[wr_idx] <= wr_data;
    end
  end

  assign rd_ctr_o = pht_q[rd_idx_i];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch predictor: global history XOR PC indexes a table
// of saturating counters; history is repaired from execute, trained at commit.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned HIST_W   = BP_HIST_W,
  parameter int unsigned IDX_W    = BP_IDX_W,
  parameter int unsigned CTR_W    = BP_CTR_W,
  parameter int unsigned CTR_INIT = BP_CTR_INIT,
  parameter int unsigned PC_W     = BP_PC_W,
  parameter int unsigned PC_LSB   = BP_PC_LSB
) (
  input  logic              clk_i,
  input  logic              rst,
  output logic              ready_o,
  input  logic              f_valid_i,
  input  logic [PC_W-1:0]   f_pc_i,
  output logic              f_predict_o,
  output logic [HIST_W-1:0] f_history_o,
  input  logic              ex_repair_valid_i,
  input  logic [HIST_W-1:0] ex_repair_history_i,
  input  logic              ex_repair_taken_i,
  input  logic              tr_valid_i,
  input  logic [PC_W-1:0]   tr_pc_i,
  input  logic [HIST_W-1:0] tr_history_i,
  input  logic              tr_taken_i
);

  if (HIST_W > IDX_W) begin : g_bad_hist_w
    $error("gshare_predictor: HIST_W must not exceed IDX_W");
  end
  if (CTR_W < 1 || CTR_W > 32) begin : g_bad_ctr_w
    $error("gshare_predictor: CTR_W must be in 1..32");
  end
  if (PC_LSB + IDX_W > PC_W) begin : g_bad_pc_lsb
    $error("gshare_predictor: PC_LSB + IDX_W exceeds PC_W");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  bp_state_e         state_q, state_d;
  logic [IDX_W-1:0]  init_ptr_q, init_ptr_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;

  logic              sweep;
  logic              tr_en;
  logic [IDX_W-1:0]  f_idx;
  logic [IDX_W-1:0]  tr_idx;
  logic [CTR_W-1:0]  f_ctr;
  logic [HIST_W-1:0] rep_shift;
  logic [HIST_W-1:0] spec_shift;
  logic              unused_ok;

  assign f_idx  = f_pc_i[PC_LSB +: IDX_W] ^ IDX_W'(ghr_q);
  assign tr_idx = tr_pc_i[PC_LSB +: IDX_W] ^ IDX_W'(tr_history_i);

  // A one-bit history has nothing to shift; the new bit is the whole GHR.
  if (HIST_W == 1) begin : g_hist_one
    assign rep_shift  = ex_repair_taken_i;
    assign spec_shift = f_predict_o;
  end else begin : g_hist_multi
    assign rep_shift  = {ex_repair_history_i[HIST_W-2:0], ex_repair_taken_i};
    assign spec_shift = {ghr_q[HIST_W-2:0], f_predict_o};
  end

  sat_ctr_table #(
    .IDX_W   (IDX_W),
    .CTR_W   (CTR_W),
    .CTR_INIT(CTR_INIT)
  ) u_pht (
    .clk_i      (clk_i),
    .sweep_i    (sweep),
    .sweep_idx_i(init_ptr_q),
    .rd_idx_i   (f_idx),
    .rd_ctr_o   (f_ctr),
    .upd_en_i   (tr_en),
    .upd_idx_i  (tr_idx),
    .upd_taken_i(tr_taken_i)
  );

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    sweep      = 1'b0;
    tr_en      = 1'b0;
    case (state_q)
      BP_INIT: begin
        sweep      = 1'b1;
        init_ptr_d = init_ptr_q + IDX_W'(1);
        ghr_d      = '0;
        if (init_ptr_q == LAST_IDX) begin
          state_d = BP_RUN;
        end
      end
      BP_RUN: begin
        tr_en = tr_valid_i;
        // A repair flushes fetch, so the speculative shift of that cycle is lost.
        if (ex_repair_valid_i) begin
          ghr_d = rep_shift;
        end else if (f_valid_i) begin
          ghr_d = spec_shift;
        end
      end
      default: begin
        state_d = BP_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= BP_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
    end
  end

  assign ready_o     = (state_q == BP_RUN);
  assign f_predict_o = ready_o & f_ctr[CTR_W-1];
  assign f_history_o = ghr_q;

  // Only a slice of each PC and the counter MSB are meaningful here.
  assign unused_ok = ^{f_pc_i, tr_pc_i, ex_repair_history_i, f_ctr};

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed vector table for the
// listed corner cases plus randomized traffic against an array-based model.
module tb_gshare_predictor;

  localparam int HW      = 7;
  localparam int IW      = 7;
  localparam int CW      = 2;
  localparam int PW      = 32;
  localparam int ENTRIES = 128;
  localparam int CMAX    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          f_valid;
  logic [PW-1:0] f_pc;
  logic          f_predict;
  logic [HW-1:0] f_history;
  logic          rep_v;
  logic [HW-1:0] rep_h;
  logic          rep_t;
  logic          tr_v;
  logic [PW-1:0] tr_pc;
  logic [HW-1:0] tr_h;
  logic          tr_t;

  always #5 clk = ~clk;

  gshare_predictor #(
    .HIST_W  (HW),
    .IDX_W   (IW),
    .CTR_W   (CW),
    .CTR_INIT(1),
    .PC_W    (PW),
    .PC_LSB  (0)
  ) dut (
    .clk_i              (clk),
    .rst                (rst),
    .ready_o            (ready),
    .f_valid_i          (f_valid),
    .f_pc_i             (f_pc),
    .f_predict_o        (f_predict),
    .f_history_o        (f_history),
    .ex_repair_valid_i  (rep_v),
    .ex_repair_history_i(rep_h),
    .ex_repair_taken_i  (rep_t),
    .tr_valid_i         (tr_v),
    .tr_pc_i            (tr_pc),
    .tr_history_i       (tr_h),
    .tr_taken_i         (tr_t)
  );

  int checks = 0;
  int errors = 0;

  int pht [ENTRIES];
  int ghr;

  typedef struct {
    logic        f_valid;
    logic [31:0] pc;
    logic        rep_v;
    logic [6:0]  rep_h;
    logic        rep_t;
    logic        tr_v;
    logic [31:0] tr_pc;
    logic [6:0]  tr_h;
    logic        tr_t;
    logic        exp_pred;
    logic [6:0]  exp_hist;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    f_valid = 1'b0; f_pc = '0;
    rep_v = 1'b0; rep_h = '0; rep_t = 1'b0;
    tr_v = 1'b0; tr_pc = '0; tr_h = '0; tr_t = 1'b0;
  endtask

  task automatic junk_inputs();
    f_valid = 1'b1; f_pc = $urandom();
    rep_v = 1'b1; rep_h = 7'h55; rep_t = 1'b1;
    tr_v = 1'b1; tr_pc = 32'h0; tr_h = '0; tr_t = 1'b1;
  endtask

  // Counts edges from release of reset until ready; outputs must stay quiet.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (!ready) begin
        chk("init_pred", 32'(f_predict), 32'd0);
        chk("init_hist", 32'(f_history), 32'd0);
      end
    end
    idle_inputs();
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) pht[i] = 1;
    ghr = 0;
  endtask

  task automatic run_random(input int ncyc);
    int idx;
    int tidx;
    int exp_pred;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      f_valid = ($urandom_range(0, 1) == 1);
      f_pc    = ($urandom() & 32'hFFFF_FF80) | 32'($urandom_range(0, 15));
      rep_v   = ($urandom_range(0, 7) == 0);
      rep_h   = 7'($urandom());
      rep_t   = 1'($urandom());
      tr_v    = ($urandom_range(0, 1) == 1);
      tr_pc   = ($urandom() & 32'hFFFF_FF80) | 32'($urandom_range(0, 15));
      tr_h    = 7'($urandom_range(0, 3));
      tr_t    = ($urandom_range(0, 2) != 0);
      #1;
      idx      = int'(f_pc % ENTRIES) ^ ghr;
      exp_pred = (pht[idx] > CMAX / 2) ? 1 : 0;
      chk("rand_pred", 32'(f_predict), 32'(exp_pred));
      chk("rand_hist", 32'(f_history), 32'(ghr));
      if (tr_v) begin
        tidx = int'(tr_pc % ENTRIES) ^ int'(tr_h);
        if (tr_t) pht[tidx] = (pht[tidx] == CMAX) ? CMAX : pht[tidx] + 1;
        else      pht[tidx] = (pht[tidx] == 0) ? 0 : pht[tidx] - 1;
      end
      if (rep_v)        ghr = ((int'(rep_h) * 2) + int'(rep_t)) % ENTRIES;
      else if (f_valid) ghr = ((ghr * 2) + exp_pred) % ENTRIES;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    int n;

    // {f_valid, pc, rep_v, rep_h, rep_t, tr_v, tr_pc, tr_h, tr_t, exp_pred, exp_hist}
    vecs[0]  = '{1'b0, 32'h10, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h00, 1'b1, 1'b0, 7'h00};
    vecs[1]  = '{1'b0, 32'h10, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h00, 1'b1, 1'b1, 7'h00};
    vecs[2]  = '{1'b0, 32'h10, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h00, 1'b1, 1'b1, 7'h00};
    vecs[3]  = '{1'b0, 32'h10, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h00, 1'b1, 1'b1, 7'h00};
    vecs[4]  = '{1'b0, 32'h10, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h00, 1'b0, 1'b1, 7'h00};
    vecs[5]  = '{1'b0, 32'h10, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h00, 1'b0, 1'b1, 7'h00};
    vecs[6]  = '{1'b0, 32'h10, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h00, 1'b0, 1'b0, 7'h00};
    vecs[7]  = '{1'b0, 32'h10, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h00, 1'b0, 1'b0, 7'h00};
    vecs[8]  = '{1'b0, 32'h10, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h00, 1'b0, 1'b0, 7'h00};
    vecs[9]  = '{1'b0, 32'h10, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h00, 1'b0, 1'b0, 7'h00};
    vecs[10] = '{1'b0, 32'h10, 1'b0, 7'h00, 1'b0, 1'b0, 32'h00, 7'h00, 1'b0, 1'b0, 7'h00};
    vecs[11] = '{1'b0, 32'h20, 1'b0, 7'h00, 1'b0, 1'b1, 32'h20, 7'h00, 1'b1, 1'b0, 7'h00};
    vecs[12] = '{1'b0, 32'h20, 1'b0, 7'h00, 1'b0, 1'b1, 32'h20, 7'h00, 1'b1, 1'b1, 7'h00};
    vecs[13] = '{1'b1, 32'h20, 1'b0, 7'h00, 1'b0, 1'b0, 32'h00, 7'h00, 1'b0, 1'b1, 7'h00};
    vecs[14] = '{1'b1, 32'h20, 1'b0, 7'h00, 1'b0, 1'b0, 32'h00, 7'h00, 1'b0, 1'b0, 7'h01};
    vecs[15] = '{1'b1, 32'h22, 1'b0, 7'h00, 1'b0, 1'b0, 32'h00, 7'h00, 1'b0, 1'b1, 7'h02};
    vecs[16] = '{1'b0, 32'h00, 1'b0, 7'h00, 1'b0, 1'b0, 32'h00, 7'h00, 1'b0, 1'b0, 7'h05};
    vecs[17] = '{1'b1, 32'h20, 1'b1, 7'h03, 1'b0, 1'b0, 32'h00, 7'h00, 1'b0, 1'b0, 7'h05};
    vecs[18] = '{1'b0, 32'h26, 1'b0, 7'h00, 1'b0, 1'b0, 32'h00, 7'h00, 1'b0, 1'b1, 7'h06};
    vecs[19] = '{1'b0, 32'h40, 1'b0, 7'h00, 1'b0, 1'b1, 32'h46, 7'h00, 1'b1, 1'b0, 7'h06};
    vecs[20] = '{1'b0, 32'h40, 1'b0, 7'h00, 1'b0, 1'b0, 32'h00, 7'h00, 1'b0, 1'b1, 7'h06};
    vecs[21] = '{1'b0, 32'h40, 1'b1, 7'h41, 1'b1, 1'b1, 32'h46, 7'h00, 1'b0, 1'b1, 7'h06};
    vecs[22] = '{1'b0, 32'h45, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h05, 1'b1, 1'b0, 7'h03};
    vecs[23] = '{1'b0, 32'h12, 1'b0, 7'h00, 1'b0, 1'b1, 32'h10, 7'h05, 1'b1, 1'b0, 7'h03};
    vecs[24] = '{1'b0, 32'h16, 1'b0, 7'h00, 1'b0, 1'b0, 32'h00, 7'h00, 1'b0, 1'b1, 7'h03};

    // Reset held 3 cycles with junk on every input.
    rst = 1'b1;
    junk_inputs();
    @(posedge clk); #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_pred", 32'(f_predict), 32'd0);
    chk("rst_hist", 32'(f_history), 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    chk("init_cycles", 32'(n), 32'd128);

    for (int i = 0; i < ENTRIES; i++) begin
      @(negedge clk);
      f_pc = 32'(i);
      #1;
      chk("post_init_pred", 32'(f_predict), 32'd0);
      chk("post_init_hist", 32'(f_history), 32'd0);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      f_valid = vecs[i].f_valid; f_pc  = vecs[i].pc;
      rep_v   = vecs[i].rep_v;   rep_h = vecs[i].rep_h; rep_t = vecs[i].rep_t;
      tr_v    = vecs[i].tr_v;    tr_pc = vecs[i].tr_pc; tr_h  = vecs[i].tr_h;
      tr_t    = vecs[i].tr_t;
      #1;
      chk($sformatf("vec%0d_pred", i), 32'(f_predict), 32'(vecs[i].exp_pred));
      chk($sformatf("vec%0d_hist", i), 32'(f_history), 32'(vecs[i].exp_hist));
    end
    @(negedge clk);
    idle_inputs();

    // Reset partway through the sweep restarts it from entry 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    chk("reinit_cycles", 32'(n), 32'd128);

    model_reset();
    run_random(39);
    // Guarantee a non-zero history before the mid-run reset.
    @(negedge clk);
    rep_v = 1'b1; rep_h = 7'h7F; rep_t = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("pre_rst_hist", 32'(f_history), 32'h7F);

    @(negedge clk);
    rst = 1'b1;
    junk_inputs();
    @(posedge clk); #1;
    chk("midrun_ready", 32'(ready), 32'd0);
    chk("midrun_hist", 32'(f_history), 32'd0);
    chk("midrun_pred", 32'(f_predict), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    f_pc = 32'h0;
    wait_ready(n);
    chk("midrun_init_cycles", 32'(n), 32'd128);

    for (int i = 0; i < ENTRIES; i++) begin
      @(negedge clk);
      f_pc = 32'(i);
      #1;
      chk("sweep_clean_pred", 32'(f_predict), 32'd0);
    end
    @(negedge clk);
    idle_inputs();

    model_reset();
    run_random(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised gshare conditional-branch predictor for the fetch stage. It replaces the fixed 7-bit-history, 128-entry predictor with configurable history width, table depth and counter width. It also adds a table-initialisation sweep with a ready flag, and defined priority between history repair, speculative update and training. Fetch gets a prediction and a history snapshot in the same cycle; execute repairs history on a mispredict; the commit stage trains the table.

## Interface
- `HIST_W`, 7: global history register (GHR) width; must satisfy `HIST_W <= IDX_W`.
- `IDX_W`, 7: PHT index width; the table has `2**IDX_W` entries.
- `CTR_W`, 2: saturating counter width; must be ≥1.
- `CTR_INIT`, 1: counter value written by the init sweep (weakly not-taken).
- `PC_W`, 32: PC width.
- `PC_LSB`, 0: lowest PC bit used for the index.

Ports:
- `clk_i`, in, 1: clock; single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `ready_o`, out, 1: table initialised; 0 during the init sweep.
- `f_valid_i`, in, 1: a conditional branch is being fetched this cycle.
- `f_pc_i`, in, `PC_W`: fetch PC.
- `f_predict_o`, out, 1: predicted direction (1 = taken).
- `f_history_o`, out, `HIST_W`: GHR value used for this prediction; travels down the pipe with the branch.
- `ex_repair_valid_i`, in, 1: execute detected a mispredicted branch.
- `ex_repair_history_i`, in, `HIST_W`: history snapshot carried by that branch.
- `ex_repair_taken_i`, in, 1: actual outcome of that branch.
- `tr_valid_i`, in, 1: a branch commits; train the PHT.
- `tr_pc_i`, in, `PC_W`: PC of the committing branch.
- `tr_history_i`, in, `HIST_W`: history snapshot of the committing branch.
- `tr_taken_i`, in, 1: actual outcome of the committing branch.

## Operation
- Index function: `idx(pc,h) = pc[PC_LSB +: IDX_W] ^ {{(IDX_W-HIST_W){1'b0}}, h}`.
- Fetch index is `idx(f_pc_i, GHR)`. Train index is `idx(tr_pc_i, tr_history_i)`.
- `f_predict_o` is the MSB of `PHT[fetch index]` when in RUN. It is forced to 0 in INIT.
- `f_history_o` equals the current GHR.

FSM states:
- INIT (entered on reset):
  - Writes `CTR_INIT` to entry `init_ptr` each cycle, with `init_ptr` running 0 → `2**IDX_W-1`.
  - After the last entry, goes to RUN.
  - `ready_o=0`. All fetch, repair and train inputs are ignored; the GHR holds 0.
- RUN: `ready_o=1`. Stays in RUN until `rst`.

GHR update in RUN, by priority:
- Repair: `GHR <= {ex_repair_history_i[HIST_W-2:0], ex_repair_taken_i}`.
- Otherwise, if `f_valid_i`: `GHR <= {GHR[HIST_W-2:0], f_predict_o}`.
- When both fire in the same cycle, the speculative fetch update is dropped, because fetch is being flushed.
- For `HIST_W==1`, the shifted-in bit alone forms the new GHR.

Training in RUN, when `tr_valid_i`:
- Taken: counter `+1`, saturating at `2**CTR_W-1`.
- Not taken: counter `-1`, saturating at 0.
- The update is a read-modify-write of a single entry and is written at the clock edge.

Boundary cases:
- Train and fetch hit the same index in the same cycle: fetch sees the pre-update counter (no bypass).
- Training is independent of repair; a repair and a train in the same cycle both take effect.
- `rst` asserted mid-INIT or mid-RUN: on the next edge `init_ptr=0` and `GHR=0`, and the sweep restarts from entry 0.

## Timing
- Reset values: `ready_o=0`, `f_predict_o=0`, `f_history_o=0`, `init_ptr=0`.
- Init sweep takes exactly `2**IDX_W` cycles after `rst` deasserts; `ready_o` rises on the following edge.
- Prediction and history output are combinational from `f_pc_i` and registered state: 0-cycle latency.
- GHR, PHT and FSM changes are visible from the cycle after the triggering edge.

## Structure
- Shared package `bp_pkg`:
  - FSM state enum (`BP_INIT`, `BP_RUN`).
  - Default parameter constants.
  - A saturating-counter update function.
- Sub-module `sat_ctr_table`: PHT storage with one combinational read port, one write port and the sweep write mux.
- FSM and GHR stay in `gshare_predictor`.
- Elaboration-time assertions enforce `HIST_W <= IDX_W` and `CTR_W >= 1`.

## Test plan
- **Reset/init:** hold `rst` 3 cycles, release → `ready_o` rises exactly 128 cycles later (defaults); every lookup then returns `f_predict_o=0` and `f_history_o=0`.
- **Train saturation:** PC 0x10, history 0; train taken ×4 → counter 3, `f_predict_o=1`; train not-taken ×5 → counter 0; one more not-taken keeps it at 0.
- **Speculative history:** after init, 3 fetches with predictions 1,0,1 → GHR=7'b0000101.
- **Repair priority:** repair (history 7'b0000011, taken=0) and `f_valid_i` in the same cycle → GHR=7'b0000110; the fetch shift is discarded.
- **Same-index train/fetch:** counter=1; train taken and fetch the same index in the same cycle → `f_predict_o=0` this cycle, 1 the next cycle.
- **Reset mid-run:** assert `rst` at cycle 40 of RUN with GHR≠0 → GHR=0, `ready_o=0`, sweep restarts at entry 0; a train during the sweep has no effect.
